// File: rtl/multicore_pkg.sv
// Host-index type and the helpers that fold/unfold the host index in a_source/d_source.
package multicore_pkg;

    localparam int NumHostsMax = 16;
    localparam int HostIdxW    = $clog2(NumHostsMax);

    typedef logic [HostIdxW-1:0] host_idx_t;

    function automatic logic [tlul_pkg::TL_AIW-1:0] source_strip(
        input logic [tlul_pkg::TL_AIW-1:0] src, input int unsigned id_w);
        return src & ({tlul_pkg::TL_AIW{1'b1}} >> id_w);
    endfunction

    // Host index occupies the top id_w bits of the device-side source.
    function automatic logic [tlul_pkg::TL_AIW-1:0] compose_source(
        input host_idx_t idx, input logic [tlul_pkg::TL_AIW-1:0] src, input int unsigned id_w);
        logic [tlul_pkg::TL_AIW-1:0] wide;
        wide = {{(tlul_pkg::TL_AIW-HostIdxW){1'b0}}, idx};
        return (wide << (tlul_pkg::TL_AIW - id_w)) | source_strip(src, id_w);
    endfunction

    function automatic host_idx_t source_host(
        input logic [tlul_pkg::TL_AIW-1:0] src, input int unsigned id_w);
        logic [tlul_pkg::TL_AIW-1:0] sh;
        sh = src >> (tlul_pkg::TL_AIW - id_w);
        return sh[HostIdxW-1:0];
    endfunction

endpackage

// File: rtl/tlul_pkg.sv
// TL-UL channel types shared by the arbiter and its hosts/device.
package tlul_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_SZW = 2;
    localparam int TL_DBW = TL_DW / 8;

    typedef struct packed {
        logic              a_valid;
        logic [2:0]        a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        logic [2:0]        d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/multicore_tl_arbiter_if.sv
// Signal bundle for wiring multicore_tl_arbiter; arb modport mirrors the top's port directions.
interface multicore_tl_arbiter_if #(
    parameter int NumHosts = 4
);
    tlul_pkg::tl_h2d_t [NumHosts-1:0] tl_h_i;
    tlul_pkg::tl_d2h_t [NumHosts-1:0] tl_h_o;
    tlul_pkg::tl_h2d_t                tl_d_o;
    tlul_pkg::tl_d2h_t                tl_d_i;
    logic                             busy_o;
    logic                             resp_err_o;

    modport arb  (input tl_h_i, tl_d_i, output tl_h_o, tl_d_o, busy_o, resp_err_o);
    modport host (output tl_h_i, tl_d_i, input tl_h_o, tl_d_o, busy_o, resp_err_o);
endinterface

// File: rtl/multicore_rr_arb.sv
// Combinational round-robin pick starting at ptr; hold forces the grant to hold_idx.
module multicore_rr_arb #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          hold,
    input  logic [IW-1:0] hold_idx,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid
);

    logic [IW-1:0] cand;

    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = '0;
        if (hold) begin
            gnt_idx   = hold_idx;
            gnt_valid = 1'b1;
        end else begin
            // Walk farthest-first so the candidate nearest ptr is written last and wins.
            for (int k = N - 1; k >= 0; k--) begin
                cand = IW'((int'(ptr) + k) % N);
                if (req[cand]) begin
                    gnt_idx   = cand;
                    gnt_valid = 1'b1;
                end
            end
        end
        gnt = gnt_valid ? ({{(N-1){1'b0}}, 1'b1} << gnt_idx) : '0;
    end

endmodule

// File: rtl/multicore_tl_arbiter.sv
// N-to-1 TL-UL arbiter: round-robin A channel with per-host outstanding limit, D routed by source.
module multicore_tl_arbiter
    import tlul_pkg::*;
    import multicore_pkg::*;
#(
    parameter int NumHosts       = 4,
    parameter int MaxOutstanding = 2,
    parameter int HostIdWidth    = $clog2(NumHosts)
) (
    input  logic                    clk_sys_i,
    input  logic                    rst_sys_i,
    input  tl_h2d_t [NumHosts-1:0]  tl_h_i,
    output tl_d2h_t [NumHosts-1:0]  tl_h_o,
    output tl_h2d_t                 tl_d_o,
    input  tl_d2h_t                 tl_d_i,
    output logic                    busy_o,
    output logic                    resp_err_o
);

    typedef logic [HostIdWidth-1:0] idx_t;
    typedef logic [3:0]             cnt_t;
    localparam cnt_t MaxCnt = cnt_t'(MaxOutstanding);

    cnt_t [NumHosts-1:0] cnt_q;
    idx_t                ptr_q, lock_idx_q;
    logic                lock_q;

    logic [NumHosts-1:0] elig, gnt, a_hs, d_hs, d_uflow;
    idx_t                gnt_idx, d_idx;
    logic                gnt_valid, d_mapped, a_fire;

    always_comb begin
        for (int i = 0; i < NumHosts; i++)
            elig[i] = tl_h_i[i].a_valid && (cnt_q[i] < MaxCnt);
    end

    multicore_rr_arb #(.N(NumHosts), .IW(HostIdWidth)) u_arb (
        .req       (elig),
        .ptr       (ptr_q),
        .hold      (lock_q),
        .hold_idx  (lock_idx_q),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    assign d_idx    = idx_t'(source_host(tl_d_i.d_source, HostIdWidth));
    assign d_mapped = int'(d_idx) < NumHosts;

    always_comb begin
        tl_d_o          = tl_h_i[gnt_idx];
        tl_d_o.a_valid  = !rst_sys_i && gnt_valid && tl_h_i[gnt_idx].a_valid;
        tl_d_o.a_source = compose_source(host_idx_t'(gnt_idx), tl_h_i[gnt_idx].a_source, HostIdWidth);
        // Unmapped responses are sunk so they cannot wedge the device.
        tl_d_o.d_ready  = rst_sys_i ? 1'b0 : (d_mapped ? tl_h_i[d_idx].d_ready : 1'b1);
    end

    assign a_fire = tl_d_o.a_valid && tl_d_i.a_ready;

    always_comb begin
        for (int i = 0; i < NumHosts; i++) begin
            tl_h_o[i] = '0;
            if (!rst_sys_i && tl_d_i.d_valid && d_mapped && d_idx == idx_t'(i)) begin
                tl_h_o[i]          = tl_d_i;
                tl_h_o[i].d_source = source_strip(tl_d_i.d_source, HostIdWidth);
            end
            tl_h_o[i].a_ready = tl_d_o.a_valid && gnt[i] && tl_d_i.a_ready;
            a_hs[i]    = tl_h_o[i].a_ready;
            d_hs[i]    = tl_h_o[i].d_valid && tl_h_i[i].d_ready;
            d_uflow[i] = d_hs[i] && !a_hs[i] && (cnt_q[i] == '0);
        end
    end

    assign resp_err_o = !rst_sys_i && ((tl_d_i.d_valid && !d_mapped) || |d_uflow);

    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < NumHosts; i++)
            busy_o = busy_o | (cnt_q[i] != '0);
    end

    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            cnt_q      <= '0;
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            lock_q     <= tl_d_o.a_valid && !tl_d_i.a_ready;
            lock_idx_q <= gnt_idx;
            if (a_fire)
                ptr_q <= (gnt_idx == idx_t'(NumHosts - 1)) ? '0 : gnt_idx + 1'b1;
            for (int i = 0; i < NumHosts; i++) begin
                if (a_hs[i] && !d_hs[i])
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                else if (d_hs[i] && !a_hs[i] && cnt_q[i] != '0)
                    cnt_q[i] <= cnt_q[i] - 1'b1;
            end
        end
    end

    // Source bits above the host-index field are dropped, so hosts must keep them zero.
    for (genvar g = 0; g < NumHosts; g++) begin : g_src_chk
        a_src_upper_zero: assert property (@(posedge clk_sys_i) disable iff (rst_sys_i)
            tl_h_i[g].a_valid |-> ((tl_h_i[g].a_source >> (TL_AIW - HostIdWidth)) == '0));
    end

endmodule

// File: tb/tb_multicore_tl_arbiter.sv
// Directed bench for multicore_tl_arbiter (4-host model-checked instance plus a 3-host instance).
module tb_multicore_tl_arbiter;
    import tlul_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicore_tl_arbiter_if #(.NumHosts(4)) if4 ();
    multicore_tl_arbiter_if #(.NumHosts(3)) if3 ();

    multicore_tl_arbiter #(.NumHosts(4), .MaxOutstanding(2)) u4 (
        .clk_sys_i(clk), .rst_sys_i(rst),
        .tl_h_i(if4.tl_h_i), .tl_h_o(if4.tl_h_o), .tl_d_o(if4.tl_d_o), .tl_d_i(if4.tl_d_i),
        .busy_o(if4.busy_o), .resp_err_o(if4.resp_err_o)
    );

    multicore_tl_arbiter #(.NumHosts(3), .MaxOutstanding(2)) u3 (
        .clk_sys_i(clk), .rst_sys_i(rst),
        .tl_h_i(if3.tl_h_i), .tl_h_o(if3.tl_h_o), .tl_d_o(if3.tl_d_o), .tl_d_i(if3.tl_d_i),
        .busy_o(if3.busy_o), .resp_err_o(if3.resp_err_o)
    );

    int total = 0;
    int bad   = 0;
    bit done  = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Reference model of the 4-host instance: outstanding counts, rotating start, held grant.
    int  m_cnt [4];
    int  m_ptr  = 0;
    int  m_lock = -1;
    int  g, di, c;
    bit  av, rdy, dv, dhs, ahs, exp_err, exp_busy;

    always @(negedge clk) begin
        if (!done) begin
            if (rst) begin
                chk("rst_a_valid", if4.tl_d_o.a_valid, 0);
                chk("rst_d_ready", if4.tl_d_o.d_ready, 0);
                chk("rst_busy", if4.busy_o, 0);
                chk("rst_err", if4.resp_err_o, 0);
                for (int i = 0; i < 4; i++) begin
                    chk($sformatf("rst_a_ready%0d", i), if4.tl_h_o[i].a_ready, 0);
                    chk($sformatf("rst_d_valid%0d", i), if4.tl_h_o[i].d_valid, 0);
                    m_cnt[i] = 0;
                end
                m_ptr  = 0;
                m_lock = -1;
            end else begin
                g = -1;
                if (m_lock >= 0) g = m_lock;
                else for (int k = 0; k < 4; k++) begin
                    c = (m_ptr + k) % 4;
                    if (g < 0 && if4.tl_h_i[c].a_valid && m_cnt[c] < 2) g = c;
                end
                av  = (g >= 0) && if4.tl_h_i[g].a_valid;
                rdy = if4.tl_d_i.a_ready;
                chk("a_valid", if4.tl_d_o.a_valid, av);
                if (av) begin
                    chk("a_source", if4.tl_d_o.a_source, g * 64 + (if4.tl_h_i[g].a_source & 8'h3f));
                    chk("a_address", if4.tl_d_o.a_address, if4.tl_h_i[g].a_address);
                    chk("a_data", if4.tl_d_o.a_data, if4.tl_h_i[g].a_data);
                end
                dv = if4.tl_d_i.d_valid;
                di = int'(if4.tl_d_i.d_source) / 64;
                for (int i = 0; i < 4; i++) begin
                    chk($sformatf("a_ready%0d", i), if4.tl_h_o[i].a_ready, av && rdy && i == g);
                    chk($sformatf("d_valid%0d", i), if4.tl_h_o[i].d_valid, dv && i == di);
                    if (dv && i == di) begin
                        chk($sformatf("d_source%0d", i), if4.tl_h_o[i].d_source, if4.tl_d_i.d_source % 64);
                        chk($sformatf("d_data%0d", i), if4.tl_h_o[i].d_data, if4.tl_d_i.d_data);
                    end
                end
                chk("d_ready", if4.tl_d_o.d_ready, if4.tl_h_i[di].d_ready);
                ahs = av && rdy;
                dhs = dv && if4.tl_h_i[di].d_ready;
                exp_err  = dhs && m_cnt[di] == 0 && !(ahs && g == di);
                exp_busy = 1'b0;
                for (int i = 0; i < 4; i++) if (m_cnt[i] > 0) exp_busy = 1'b1;
                chk("resp_err", if4.resp_err_o, exp_err);
                chk("busy", if4.busy_o, exp_busy);
                if (ahs) m_ptr = (g + 1) % 4;
                m_lock = (av && !rdy) ? g : -1;
                if (ahs && !(dhs && di == g)) m_cnt[g]++;
                if (dhs && !(ahs && di == g) && m_cnt[di] > 0) m_cnt[di]--;
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic req(input int h, input logic v, input logic [7:0] src, input logic [31:0] adr);
        if4.tl_h_i[h].a_valid   = v;
        if4.tl_h_i[h].a_source  = src;
        if4.tl_h_i[h].a_address = adr;
        if4.tl_h_i[h].a_data    = adr ^ 32'h5a5a_0000;
        if4.tl_h_i[h].a_opcode  = 3'h4;
        if4.tl_h_i[h].a_mask    = 4'hf;
    endtask

    task automatic dresp(input logic v, input logic [7:0] src);
        if4.tl_d_i.d_valid  = v;
        if4.tl_d_i.d_source = src;
        if4.tl_d_i.d_data   = {24'h0, src} + 32'h1000;
        if4.tl_d_i.d_opcode = 3'h1;
    endtask

    initial begin
        if4.tl_h_i = '0;
        if3.tl_h_i = '0;
        for (int i = 0; i < 4; i++) if4.tl_h_i[i].d_ready = 1'b1;
        for (int i = 0; i < 3; i++) if3.tl_h_i[i].d_ready = 1'b1;
        if4.tl_d_i = '0;
        if3.tl_d_i = '0;
        if4.tl_d_i.a_ready = 1'b1;
        req(0, 1, 8'h11, 32'h100);
        req(2, 1, 8'h22, 32'h200);
        smp();
        chk("lit_rst_a_valid", if4.tl_d_o.a_valid, 0);
        chk("lit_rst_a_ready0", if4.tl_h_o[0].a_ready, 0);
        // Two simultaneous requesters: host 0 then host 2, first grant right after reset.
        nxt(); rst = 1'b0;
        smp();
        chk("lit_first_src", if4.tl_d_o.a_source, 8'h11);
        chk("lit_first_rdy0", if4.tl_h_o[0].a_ready, 1);
        chk("lit_first_rdy2", if4.tl_h_o[2].a_ready, 0);
        nxt(); req(0, 0, 8'h11, 32'h100);
        smp();
        chk("lit_second_src", if4.tl_d_o.a_source, 8'hA2);
        chk("lit_second_rdy2", if4.tl_h_o[2].a_ready, 1);
        nxt(); req(2, 0, 8'h22, 32'h200); dresp(1, 8'h11);
        smp();
        chk("lit_d0_valid", if4.tl_h_o[0].d_valid, 1);
        chk("lit_d0_src", if4.tl_h_o[0].d_source, 8'h11);
        nxt(); dresp(1, 8'hA2);
        smp();
        chk("lit_d2_src", if4.tl_h_o[2].d_source, 8'h22);
        nxt(); dresp(0, 8'h00);
        smp();
        chk("lit_idle_busy", if4.busy_o, 0);
        // Stalled device: host 1 stays locked even though the rotation favours host 3.
        nxt(); if4.tl_d_i.a_ready = 1'b0; req(1, 1, 8'h05, 32'h1000);
        smp();
        chk("lit_lock_src_c1", if4.tl_d_o.a_source, 8'h45);
        nxt(); req(3, 1, 8'h07, 32'h3000);
        smp();
        chk("lit_lock_src_c2", if4.tl_d_o.a_source, 8'h45);
        chk("lit_lock_adr_c2", if4.tl_d_o.a_address, 32'h1000);
        nxt();
        smp();
        chk("lit_lock_src_c3", if4.tl_d_o.a_source, 8'h45);
        nxt(); if4.tl_d_i.a_ready = 1'b1;
        smp();
        chk("lit_lock_rdy1", if4.tl_h_o[1].a_ready, 1);
        nxt(); req(1, 0, 8'h05, 32'h1000);
        smp();
        chk("lit_after_lock_src", if4.tl_d_o.a_source, 8'hC7);
        nxt(); req(3, 0, 8'h07, 32'h3000); dresp(1, 8'hC5);
        smp();
        chk("lit_d3_valid", if4.tl_h_o[3].d_valid, 1);
        chk("lit_d3_src", if4.tl_h_o[3].d_source, 8'h05);
        nxt(); dresp(1, 8'h45);
        smp();
        nxt(); dresp(0, 8'h00);
        smp();
        chk("lit_busy_cleared", if4.busy_o, 0);
        // Outstanding limit: third request from host 0 waits for a response.
        nxt(); req(0, 1, 8'h01, 32'h10);
        smp();
        nxt(); req(0, 1, 8'h02, 32'h14);
        smp();
        nxt(); req(0, 1, 8'h03, 32'h18);
        smp();
        chk("lit_limit_rdy0", if4.tl_h_o[0].a_ready, 0);
        chk("lit_limit_a_valid", if4.tl_d_o.a_valid, 0);
        nxt(); dresp(1, 8'h01);
        smp();
        chk("lit_limit_still_stalled", if4.tl_h_o[0].a_ready, 0);
        nxt(); dresp(0, 8'h00);
        smp();
        chk("lit_limit_third_rdy", if4.tl_h_o[0].a_ready, 1);
        // Response to host 1 with nothing outstanding.
        nxt(); req(0, 0, 8'h03, 32'h18); dresp(1, 8'h40);
        smp();
        chk("lit_uflow_err", if4.resp_err_o, 1);
        nxt(); dresp(0, 8'h00);
        smp();
        chk("lit_uflow_err_gone", if4.resp_err_o, 0);
        // Host 2 to its limit, host 3 locked, then reset mid-transaction.
        nxt(); req(2, 1, 8'h31, 32'h2000);
        smp();
        nxt(); req(2, 1, 8'h32, 32'h2004);
        smp();
        nxt(); req(2, 0, 8'h32, 32'h2004); if4.tl_d_i.a_ready = 1'b0; req(3, 1, 8'h09, 32'h3100);
        smp();
        nxt(); req(1, 1, 8'h0A, 32'h1100);
        smp();
        chk("lit_pre_rst_lock", if4.tl_d_o.a_source, 8'hC9);
        nxt(); rst = 1'b1; if4.tl_d_i.a_ready = 1'b1;
        smp();
        chk("lit_rst_busy", if4.busy_o, 0);
        nxt(); rst = 1'b0; req(2, 1, 8'h0B, 32'h2100);
        smp();
        chk("lit_post_rst_busy", if4.busy_o, 0);
        chk("lit_post_rst_src", if4.tl_d_o.a_source, 8'h4A);
        nxt(); req(1, 0, 8'h0A, 32'h1100);
        smp();
        chk("lit_post_rst_host2", if4.tl_d_o.a_source, 8'h8B);
        nxt(); req(2, 0, 8'h0B, 32'h2100); req(3, 0, 8'h09, 32'h3100); dresp(1, 8'h00);
        smp();
        chk("lit_post_rst_uflow", if4.resp_err_o, 1);
        nxt(); dresp(0, 8'h00);
        // Three-host instance: index 3 is unmapped.
        if3.tl_d_i.d_valid  = 1'b1;
        if3.tl_d_i.d_source = 8'hC0;
        smp();
        chk("lit_unmapped_d_ready", if3.tl_d_o.d_ready, 1);
        chk("lit_unmapped_err", if3.resp_err_o, 1);
        for (int i = 0; i < 3; i++)
            chk($sformatf("lit_unmapped_d_valid%0d", i), if3.tl_h_o[i].d_valid, 0);
        chk("lit_unmapped_busy", if3.busy_o, 0);
        nxt(); if3.tl_d_i.d_valid = 1'b0;
        smp();
        chk("lit_unmapped_err_gone", if3.resp_err_o, 0);
        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
